// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: response record and constants shared by the register bus adapter
package reg_bus_pkg;
  localparam int RSP_DW = 32;
  typedef struct packed {
    logic [RSP_DW-1:0] rdata;
    logic              err;
  } reg_rsp_t;
  localparam reg_rsp_t RSP_ZERO = '0;
endpackage

// File: rtl/reg_bus_rsp_fifo.sv
// reg_bus_rsp_fifo: in-order response buffer between device strobes and host response channel
// ports: push_i/wdata_i enqueue, pop_i dequeue, rdata_o head (zero when empty), full_o/empty_o/count_o status
module reg_bus_rsp_fifo
  import reg_bus_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  reg_rsp_t      wdata_i,
  input  logic          pop_i,
  output reg_rsp_t      rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  reg_rsp_t mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign full_o  = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign wptr_d  = do_push ? inc(wptr_q) : wptr_q;
  assign rptr_d  = do_pop ? inc(rptr_q) : rptr_q;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);
  assign rdata_o = empty_o ? RSP_ZERO : mem_q[rptr_q];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/reg_bus_adapter.sv
// reg_bus_adapter: req/gnt/rsp host bus to single-cycle register strobe bridge for rv_timer
// host side: req_i/we_i/addr_i/wdata_i/be_i in, gnt_o out, rvalid_o/rdata_o/err_o out with rready_i back-pressure
// device side: reg_we/reg_re/reg_addr/reg_wdata/reg_be out, reg_rdata/reg_error in (valid in strobe cycle)
module reg_bus_adapter
  import reg_bus_pkg::*;
#(
  parameter int          AW        = 9,
  parameter int          DW        = 32,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          RSP_DEPTH = 2,
  localparam int         DBW       = DW / 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           req_i,
  input  logic           we_i,
  input  logic [31:0]    addr_i,
  input  logic [DW-1:0]  wdata_i,
  input  logic [DBW-1:0] be_i,
  output logic           gnt_o,
  output logic           rvalid_o,
  input  logic           rready_i,
  output logic [DW-1:0]  rdata_o,
  output logic           err_o,
  output logic           reg_we,
  output logic           reg_re,
  output logic [AW-1:0]  reg_addr,
  output logic [DW-1:0]  reg_wdata,
  output logic [DBW-1:0] reg_be,
  input  logic [DW-1:0]  reg_rdata,
  input  logic           reg_error
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  if (RSP_DEPTH < 1 || BASE_ADDR[AW-1:0] != '0) begin : g_bad_param
    $error("reg_bus_adapter: RSP_DEPTH must be >= 1 and BASE_ADDR aligned to 2**AW");
  end
  logic rdy_q, full, empty, accept, legal;
  logic [CW-1:0] count;
  reg_rsp_t push_rsp, head;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdy_q <= 1'b0;
    else rdy_q <= 1'b1;
  end
  // grant depends only on flops, so a pop in the same cycle cannot free a slot for a full FIFO
  assign gnt_o  = rdy_q & ~full;
  assign accept = req_i & gnt_o;
  assign legal  = addr_i[31:AW] == BASE_ADDR[31:AW] && addr_i[1:0] == 2'b00 && be_i != '0;
  assign reg_we    = accept & legal & we_i;
  assign reg_re    = accept & legal & ~we_i;
  assign reg_addr  = addr_i[AW-1:0];
  assign reg_wdata = wdata_i;
  assign reg_be    = be_i;
  assign push_rsp.rdata = legal & ~we_i ? reg_rdata : '0;
  assign push_rsp.err   = legal ? reg_error : 1'b1;
  reg_bus_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (accept),
    .wdata_i (push_rsp),
    .pop_i   (rvalid_o & rready_i),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  assign rvalid_o = ~empty;
  assign rdata_o  = head.rdata;
  assign err_o    = head.err;
  a_host_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    req_i && !gnt_o ##1 req_i |-> $stable({addr_i, we_i, wdata_i, be_i}));
  a_count_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count <= CW'(RSP_DEPTH));
endmodule

// File: tb/tb_reg_bus_adapter.sv
// tb_reg_bus_adapter: directed checks of the register bus adapter against a small rv_timer-like register model
module tb_reg_bus_adapter;
  logic        clk_i = 1'b0;
  logic        rst_ni, req_i, we_i, rready_i, dev_err;
  logic [31:0] addr_i, wdata_i;
  logic [3:0]  be_i;
  logic        gnt_o, rvalid_o, err_o, reg_we, reg_re;
  logic [31:0] rdata_o, reg_wdata, reg_rdata;
  logic [8:0]  reg_addr;
  logic [3:0]  reg_be;
  logic [31:0] dev_mem [128];
  int total = 0, bad = 0, we_cnt = 0, re_cnt = 0;
  logic [31:0] ill_addr [3] = '{32'h4000_0200, 32'h4000_0002, 32'h4000_0010};
  logic        ill_we   [3] = '{1'b0, 1'b0, 1'b1};
  logic [3:0]  ill_be   [3] = '{4'hF, 4'hF, 4'h0};

  always #5 clk_i = ~clk_i;

  reg_bus_adapter dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .be_i      (be_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rready_i  (rready_i),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_be    (reg_be),
    .reg_rdata (reg_rdata),
    .reg_error (dev_err)
  );

  always_comb reg_rdata = dev_mem[reg_addr[8:2]];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 128; i++) dev_mem[i] <= '0;
      dev_mem[0] <= 32'hDEAD_0000;
      dev_mem[1] <= 32'hCAFE_0004;
      dev_mem[3] <= 32'h0001_0003;
    end else if (reg_we) begin
      for (int i = 0; i < 4; i++)
        if (reg_be[i]) dev_mem[reg_addr[8:2]][i*8 +: 8] <= reg_wdata[i*8 +: 8];
    end
  end

  always @(posedge clk_i) begin
    if (reg_we) we_cnt <= we_cnt + 1;
    if (reg_re) re_cnt <= re_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req_i = 1'b1;
    we_i = w;
    addr_i = a;
    wdata_i = d;
    be_i = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    rready_i = 1'b1; dev_err = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_strobes", {reg_we, reg_re}, 0);
    rst_ni = 1'b1;
    #1 chk("gnt_first_cycle", gnt_o, 0);
    @(negedge clk_i);
    chk("gnt_after_rdy", gnt_o, 1);
    // read cfg0
    drive(1'b0, 32'h4000_000C, 32'h0, 4'hF);
    #1 chk("t1_re", reg_re, 1);
    chk("t1_addr", reg_addr, 32'h0C);
    chk("t1_rvalid_early", rvalid_o, 0);
    @(negedge clk_i);
    req_i = 1'b0;
    chk("t1_rvalid", rvalid_o, 1);
    chk("t1_rdata", rdata_o, 32'h0001_0003);
    chk("t1_err", err_o, 0);
    chk("t1_re_cnt", re_cnt, 1);
    // write then read back
    drive(1'b1, 32'h4000_0010, 32'h1234_5678, 4'hF);
    #1 chk("t2_we", reg_we, 1);
    chk("t2_re", reg_re, 0);
    chk("t2_wdata", reg_wdata, 32'h1234_5678);
    chk("t2_be", reg_be, 4'hF);
    @(negedge clk_i);
    req_i = 1'b0;
    chk("t2_rvalid", rvalid_o, 1);
    chk("t2_rdata", rdata_o, 0);
    chk("t2_err", err_o, 0);
    @(negedge clk_i);
    chk("t2_we_once", we_cnt, 1);
    chk("t2_drained", rvalid_o, 0);
    drive(1'b0, 32'h4000_0010, 32'h0, 4'hF);
    @(negedge clk_i);
    req_i = 1'b0;
    chk("t2_readback", rdata_o, 32'h1234_5678);
    chk("t2_readback_err", err_o, 0);
    // illegal accesses, back to back
    for (int i = 0; i < 3; i++) begin
      drive(ill_we[i], ill_addr[i], 32'hFFFF_FFFF, ill_be[i]);
      #1 chk($sformatf("t3_strobe%0d", i), {reg_we, reg_re}, 0);
      chk($sformatf("t3_gnt%0d", i), gnt_o, 1);
      @(negedge clk_i);
      chk($sformatf("t3_rvalid%0d", i), rvalid_o, 1);
      chk($sformatf("t3_err%0d", i), err_o, 1);
      chk($sformatf("t3_rdata%0d", i), rdata_o, 0);
    end
    req_i = 1'b0;
    chk("t3_we_cnt", we_cnt, 1);
    chk("t3_re_cnt", re_cnt, 2);
    @(negedge clk_i);
    // back-pressure with two response slots
    rready_i = 1'b0;
    drive(1'b0, 32'h4000_000C, 32'h0, 4'hF);
    #1 chk("t4_gnt1", gnt_o, 1);
    @(negedge clk_i);
    drive(1'b0, 32'h4000_0010, 32'h0, 4'hF);
    #1 chk("t4_gnt2", gnt_o, 1);
    @(negedge clk_i);
    chk("t4_rvalid", rvalid_o, 1);
    chk("t4_head1", rdata_o, 32'h0001_0003);
    drive(1'b0, 32'h4000_0004, 32'h0, 4'hF);
    #1 chk("t4_full_nogrant", gnt_o, 0);
    chk("t4_full_no_re", reg_re, 0);
    @(negedge clk_i);
    chk("t4_hold_nogrant", gnt_o, 0);
    chk("t4_hold_stable", rdata_o, 32'h0001_0003);
    rready_i = 1'b1;
    @(negedge clk_i);
    chk("t4_gnt3", gnt_o, 1);
    chk("t4_head2", rdata_o, 32'h1234_5678);
    #1 chk("t4_re3", reg_re, 1);
    @(negedge clk_i);
    req_i = 1'b0;
    chk("t4_rvalid3", rvalid_o, 1);
    chk("t4_head3", rdata_o, 32'hCAFE_0004);
    @(negedge clk_i);
    chk("t4_empty", rvalid_o, 0);
    chk("t4_re_cnt", re_cnt, 5);
    // device error on a read
    dev_err = 1'b1;
    drive(1'b0, 32'h4000_000C, 32'h0, 4'hF);
    #1 chk("t5_re", reg_re, 1);
    @(negedge clk_i);
    req_i = 1'b0;
    dev_err = 1'b0;
    chk("t5_err", err_o, 1);
    chk("t5_rdata", rdata_o, 32'h0001_0003);
    @(negedge clk_i);
    // asynchronous reset with two responses pending
    rready_i = 1'b0;
    drive(1'b0, 32'h4000_000C, 32'h0, 4'hF);
    @(negedge clk_i);
    drive(1'b0, 32'h4000_0010, 32'h0, 4'hF);
    #1 chk("t6_re2", reg_re, 1);
    @(negedge clk_i);
    drive(1'b0, 32'h4000_0004, 32'h0, 4'hF);
    chk("t6_pending", rvalid_o, 1);
    chk("t6_full", gnt_o, 0);
    #2 rst_ni = 1'b0;
    #1 chk("t6_rst_rvalid", rvalid_o, 0);
    chk("t6_rst_strobes", {reg_we, reg_re}, 0);
    chk("t6_rst_rdata", rdata_o, 0);
    chk("t6_rst_err", err_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    req_i = 1'b0;
    rready_i = 1'b1;
    #1 chk("t6_gnt_first", gnt_o, 0);
    chk("t6_no_stale0", rvalid_o, 0);
    @(negedge clk_i);
    chk("t6_gnt_up", gnt_o, 1);
    chk("t6_no_stale1", rvalid_o, 0);
    @(negedge clk_i);
    chk("t6_no_stale2", rvalid_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
